// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_arb_pkg
// Shared types and helpers for the unified-memory port arbiter.
// Rev 1.0 : initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef logic [1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    logic    is_read;
    req_id_t id;
  } inflight_t;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

  // Round-robin successor of a requester index, wrapping at num_req.
  function automatic req_id_t rr_next(input req_id_t id, input int num_req);
    int nxt;
    nxt = int'(id) + 1;
    return (nxt >= num_req) ? req_id_t'(0) : req_id_t'(nxt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_port_arbiter_if
// Requester-side and memory-side bus bundle of the memory port arbiter.
// Rev 1.0 : initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]       req_en_i;
  logic [NUM_REQ-1:0][3:0]  req_wstrb_i;
  logic [NUM_REQ-1:0][31:0] req_addr_i;
  logic [NUM_REQ-1:0][31:0] req_wdata_i;
  logic [NUM_REQ-1:0]       req_lock_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [NUM_REQ-1:0]       rvalid_o;
  logic [31:0]              rdata_o;
  logic                     enable_o;
  logic [3:0]               wstrb_o;
  logic [31:0]              addr_o;
  logic [31:0]              wvalue_o;
  logic [31:0]              rvalue_i;

  // Arbiter side
  modport slave (
    input  req_en_i, req_wstrb_i, req_addr_i, req_wdata_i, req_lock_i, rvalue_i,
    output gnt_o, rvalid_o, rdata_o, enable_o, wstrb_o, addr_o, wvalue_o
  );

  // Requesters plus memory macro side
  modport master (
    output req_en_i, req_wstrb_i, req_addr_i, req_wdata_i, req_lock_i, rvalue_i,
    input  gnt_o, rvalid_o, rdata_o, enable_o, wstrb_o, addr_o, wvalue_o
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Combinational round-robin picker: first set request at or after ptr.
// Rev 1.0 : initial release
// ============================================================================
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            ptr,
  output logic [NUM_REQ-1:0] winner,
  output req_id_t            idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [2:0]           w_pos;
  logic [2:0]           w_sum;

  // Rotate so ptr lands at bit 0, find the lowest set bit, then rotate back.
  always_comb begin
    w_dbl = {req, req} >> ptr;
    w_rot = w_dbl[NUM_REQ-1:0];
    w_pos = '0;
    for (int p = NUM_REQ - 1; p >= 0; p--) begin
      if (w_rot[p]) w_pos = 3'(p);
    end
    w_sum = {1'b0, ptr} + w_pos;
    if (w_sum >= 3'(NUM_REQ)) w_sum = w_sum - 3'(NUM_REQ);
    any    = |req;
    idx    = req_id_t'(w_sum);
    winner = any ? (NUM_REQ'(1) << w_sum) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Round-robin sharing of a single-ported memory with lockable ownership.
// Rev 1.0 : initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  mem_port_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e         r_state, w_state_nxt;
  req_id_t            r_ptr, w_ptr_nxt;
  req_id_t            r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;

  logic [NUM_REQ-1:0] w_owner_oh;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  req_id_t            w_idx;
  logic               w_any;
  logic               w_win_lock;
  logic               w_owner_lock;
  logic               w_release;

  logic [3:0]         w_wstrb;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;

  inflight_t          r_pipe [RD_LATENCY];
  inflight_t          w_issue;
  inflight_t          w_tail;

  assign w_owner_oh = NUM_REQ'(1) << r_owner;

  // Reset is also folded in here so outputs drop the instant rstn_i falls.
  always_comb begin
    w_elig = '0;
    if (rstn_i) begin
      w_elig = (r_state == LOCKED) ? (bus.req_en_i & w_owner_oh) : bus.req_en_i;
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (w_elig),
    .ptr    (r_ptr),
    .winner (w_gnt),
    .idx    (w_idx),
    .any    (w_any)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_lock_cnt_nxt = r_lock_cnt;
    w_win_lock     = |(w_gnt & bus.req_lock_i);
    w_owner_lock   = |(w_owner_oh & bus.req_lock_i);
    w_release      = 1'b0;
    if (w_any) w_ptr_nxt = rr_next(w_idx, NUM_REQ);
    case (r_state)
      ARB: begin
        if (w_win_lock) begin
          w_state_nxt    = LOCKED;
          w_owner_nxt    = w_idx;
          w_lock_cnt_nxt = CNT_W'(1);
        end
      end
      LOCKED: begin
        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        w_release      = !w_owner_lock || (r_lock_cnt == CNT_W'(LOCK_MAX));
        if (w_release) begin
          w_state_nxt    = ARB;
          w_ptr_nxt      = rr_next(r_owner, NUM_REQ);
          w_lock_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ARB;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_comb begin
    w_wstrb = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_wstrb = bus.req_wstrb_i[k];
        w_addr  = bus.req_addr_i[k];
        w_wdata = bus.req_wdata_i[k];
      end
    end
  end

  always_comb begin
    w_issue.valid   = w_any;
    w_issue.is_read = (w_wstrb == WSTRB_READ);
    w_issue.id      = w_idx;
  end

  // Shift pipe tracks who gets the read data RD_LATENCY cycles later.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < RD_LATENCY; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0] <= w_issue;
      for (int s = 1; s < RD_LATENCY; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign w_tail       = r_pipe[RD_LATENCY-1];
  assign bus.rvalid_o = (w_tail.valid && w_tail.is_read) ? (NUM_REQ'(1) << w_tail.id) : '0;
  assign bus.rdata_o  = bus.rvalue_i;
  assign bus.gnt_o    = w_gnt;
  assign bus.enable_o = w_any;
  assign bus.wstrb_o  = w_wstrb;
  assign bus.addr_o   = w_addr;
  assign bus.wvalue_o = w_wdata;

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0(bus.gnt_o));
  a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0(bus.rvalid_o));
  a_enable_matches_gnt: assert property (@(posedge clk_i) disable iff (!rstn_i)
    bus.enable_o == (|bus.gnt_o));
  a_idle_wstrb_zero: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (bus.enable_o || bus.wstrb_o == WSTRB_READ));

endmodule
`default_nettype wire
